// File: rtl/mmc1_bus_frontend.sv
// rtl/mmc1_bus_frontend.sv - MMC1 CPU-bus front end: oversampled bus sync, M2 phase tracking, write strobe generation
module mmc1_bus_frontend #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_HIGH    = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CPU_M2,
    input  logic       nCPU_ROMSEL,
    input  logic       nCPU_RW,
    input  logic       CPU_A13,
    input  logic       CPU_A14,
    input  logic       CPU_D0,
    input  logic       CPU_D7,
    output logic       WR_STB,
    output logic       WR_CLR,
    output logic       WR_D0,
    output logic [1:0] WR_SEL,
    output logic       IGN_STB,
    output logic       M2_LOST
);

    localparam int IW = $clog2(TIMEOUT + 1);
    localparam int HW = $clog2(MIN_HIGH + 1);
    // bit order {D7, D0, A14, A13, RW_n, ROMSEL_n, M2}; active-low strobes idle high
    localparam logic [6:0] SYNC_RST = 7'b0000110;

    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        ST_HIGH   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    logic [6:0]    sync_q [SYNC_STAGES];
    logic [6:0]    s_bus;
    logic          s_m2, s_romsel_n, s_rw_n, s_a13, s_a14, s_d0, s_d7;
    logic          m2_d, m2_rise, m2_edge;
    logic [IW-1:0] idle_cnt, idle_nxt;
    logic          timeout, force_low, cap_en;
    logic [HW-1:0] hi_cnt;
    logic          prev_wr;
    logic          h_qual, h_d7, h_d0;
    logic [1:0]    h_sel;
    state_t        state;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
        end else begin
            sync_q[0] <= {CPU_D7, CPU_D0, CPU_A14, CPU_A13, nCPU_RW, nCPU_ROMSEL, CPU_M2};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s_bus      = sync_q[SYNC_STAGES-1];
    assign s_m2       = s_bus[0];
    assign s_romsel_n = s_bus[1];
    assign s_rw_n     = s_bus[2];
    assign s_a13      = s_bus[3];
    assign s_a14      = s_bus[4];
    assign s_d0       = s_bus[5];
    assign s_d7       = s_bus[6];

    assign m2_rise   = s_m2 & ~m2_d;
    assign m2_edge   = s_m2 ^ m2_d;
    assign timeout   = (idle_cnt == IW'(TIMEOUT));
    assign idle_nxt  = m2_edge ? '0 : (timeout ? idle_cnt : idle_cnt + IW'(1));
    assign force_low = timeout & ~m2_edge;

    // The hold register tracks every high sample, so the last one before the fall wins
    assign cap_en = ~force_low & s_m2 &
                    ((state == ST_LOW && m2_rise) || state == ST_HIGH || state == ST_COMMIT);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            h_qual <= 1'b0;
            h_d7   <= 1'b0;
            h_d0   <= 1'b0;
            h_sel  <= 2'b00;
        end else if (cap_en) begin
            h_qual <= ~s_romsel_n & ~s_rw_n;
            h_d7   <= s_d7;
            h_d0   <= s_d0;
            h_sel  <= {s_a14, s_a13};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_LOW;
            m2_d     <= 1'b0;
            idle_cnt <= '0;
            hi_cnt   <= '0;
            prev_wr  <= 1'b0;
            WR_STB   <= 1'b0;
            WR_CLR   <= 1'b0;
            WR_D0    <= 1'b0;
            WR_SEL   <= 2'b00;
            IGN_STB  <= 1'b0;
            M2_LOST  <= 1'b0;
        end else begin
            m2_d     <= s_m2;
            idle_cnt <= idle_nxt;
            WR_STB   <= 1'b0;
            IGN_STB  <= 1'b0;

            if (m2_rise)
                M2_LOST <= 1'b0;
            else if (idle_nxt == IW'(TIMEOUT))
                M2_LOST <= 1'b1;

            if (force_low) begin
                state   <= ST_LOW;
                hi_cnt  <= '0;
                prev_wr <= 1'b0;
            end else begin
                case (state)
                    ST_LOW: begin
                        if (m2_rise) begin
                            state  <= ST_HIGH;
                            hi_cnt <= HW'(1);
                        end
                    end
                    ST_HIGH: begin
                        if (s_m2) begin
                            if (hi_cnt != HW'(MIN_HIGH)) hi_cnt <= hi_cnt + HW'(1);
                        end else if (hi_cnt < HW'(MIN_HIGH)) begin
                            state <= ST_LOW;
                        end else begin
                            state <= ST_COMMIT;
                        end
                    end
                    ST_COMMIT: begin
                        // D7 resets bypass the consecutive-write suppression
                        if (h_qual) begin
                            if (h_d7 || !prev_wr) begin
                                WR_STB  <= 1'b1;
                                WR_CLR  <= h_d7;
                                WR_D0   <= h_d0;
                                WR_SEL  <= h_sel;
                                prev_wr <= 1'b1;
                            end else begin
                                IGN_STB <= 1'b1;
                            end
                        end else begin
                            prev_wr <= 1'b0;
                        end
                        if (s_m2) begin
                            state  <= ST_HIGH;
                            hi_cnt <= HW'(1);
                        end else begin
                            state <= ST_LOW;
                        end
                    end
                    default: state <= ST_LOW;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mmc1_bus_frontend.sv
// tb/tb_mmc1_bus_frontend.sv - scoreboard bench for mmc1_bus_frontend
module tb_mmc1_bus_frontend;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       CPU_M2 = 1'b0, nCPU_ROMSEL = 1'b1, nCPU_RW = 1'b1;
    logic       CPU_A13 = 1'b0, CPU_A14 = 1'b0, CPU_D0 = 1'b0, CPU_D7 = 1'b0;
    logic       WR_STB, WR_CLR, WR_D0, IGN_STB, M2_LOST;
    logic [1:0] WR_SEL;

    typedef struct {
        int       kind;
        int       cyc;
        bit       clr;
        bit       d0;
        bit [1:0] sel;
    } exp_t;

    localparam int K_NONE = 0;
    localparam int K_WR   = 1;
    localparam int K_IGN  = 2;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    mmc1_bus_frontend #(.SYNC_STAGES(2), .MIN_HIGH(4), .TIMEOUT(255)) dut (
        .CLK(CLK), .RST(RST), .CPU_M2(CPU_M2), .nCPU_ROMSEL(nCPU_ROMSEL), .nCPU_RW(nCPU_RW),
        .CPU_A13(CPU_A13), .CPU_A14(CPU_A14), .CPU_D0(CPU_D0), .CPU_D7(CPU_D7),
        .WR_STB(WR_STB), .WR_CLR(WR_CLR), .WR_D0(WR_D0), .WR_SEL(WR_SEL),
        .IGN_STB(IGN_STB), .M2_LOST(M2_LOST)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every strobe pops one expectation
    always @(negedge CLK) begin
        if (!RST) begin
            if (WR_STB && IGN_STB) check("both_strobes", 1, 0);
            if (WR_STB || IGN_STB) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", WR_STB ? K_WR : K_IGN, K_NONE);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("strobe_kind", WR_STB ? K_WR : K_IGN, e.kind);
                    check("strobe_cycle", cyc, e.cyc);
                    if (e.kind == K_WR) begin
                        check("wr_clr", int'(WR_CLR), int'(e.clr));
                        check("wr_d0", int'(WR_D0), int'(e.d0));
                        check("wr_sel", int'(WR_SEL), int'(e.sel));
                    end
                end
            end
        end
    end

    // One M2 cycle; called at a negedge. Strobe is due 4 edges after M2 drops (sync 2 + fall detect + commit).
    task automatic bus_cycle(input bit romsel_n, input bit rw_n, input bit a14, input bit a13,
                             input bit d0, input bit d7, input int hi, input int kind);
        exp_t e;
        nCPU_ROMSEL = romsel_n;
        nCPU_RW     = rw_n;
        CPU_A14     = a14;
        CPU_A13     = a13;
        CPU_D0      = d0;
        CPU_D7      = d7;
        repeat (4) @(negedge CLK);
        CPU_M2 = 1'b1;
        repeat (hi) @(negedge CLK);
        CPU_M2 = 1'b0;
        if (kind != K_NONE) begin
            e.kind = kind;
            e.cyc  = cyc + 4;
            e.clr  = d7;
            e.d0   = d0;
            e.sel  = {a14, a13};
            exp_q.push_back(e);
        end
        repeat (6) @(negedge CLK);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check("rst_wr_stb", int'(WR_STB), 0);
        check("rst_wr_clr", int'(WR_CLR), 0);
        check("rst_wr_d0", int'(WR_D0), 0);
        check("rst_wr_sel", int'(WR_SEL), 0);
        check("rst_ign_stb", int'(IGN_STB), 0);
        check("rst_m2_lost", int'(M2_LOST), 0);
        RST = 1'b0;
        repeat (4) @(negedge CLK);

        //         romsel rw a14 a13 d0 d7 hi kind
        bus_cycle(0, 0, 0, 0, 1, 0, 6, K_WR);    // $8000 D0=1
        bus_cycle(0, 1, 0, 0, 0, 0, 6, K_NONE);  // read clears prev_wr
        bus_cycle(0, 0, 1, 1, 1, 0, 6, K_WR);    // $E000 first of RMW pair
        bus_cycle(0, 0, 1, 1, 1, 0, 6, K_IGN);   // consecutive write ignored
        bus_cycle(0, 1, 1, 1, 0, 0, 6, K_NONE);  // read
        bus_cycle(0, 0, 1, 1, 0, 0, 6, K_WR);    // write again accepted
        bus_cycle(0, 0, 0, 1, 1, 1, 6, K_WR);    // D7 reset in consecutive slot
        bus_cycle(0, 0, 1, 0, 1, 0, 6, K_IGN);   // after D7 write, D7=0 ignored
        bus_cycle(0, 0, 1, 0, 1, 0, 2, K_NONE);  // glitch: discarded, prev_wr kept
        bus_cycle(0, 0, 1, 0, 0, 0, 6, K_IGN);   // still suppressed
        bus_cycle(1, 0, 1, 0, 0, 0, 6, K_NONE);  // non-ROM write clears prev_wr
        bus_cycle(0, 0, 1, 0, 1, 0, 6, K_WR);    // $C000 accepted

        repeat (100) @(negedge CLK);
        check("m2_lost_before_timeout", int'(M2_LOST), 0);
        repeat (200) @(negedge CLK);
        check("m2_lost_after_stall", int'(M2_LOST), 1);
        bus_cycle(0, 0, 0, 0, 0, 0, 6, K_WR);    // stall cleared prev_wr
        check("m2_lost_cleared", int'(M2_LOST), 0);

        bus_cycle(0, 1, 0, 0, 0, 0, 6, K_NONE);
        bus_cycle(0, 0, 1, 1, 1, 0, 6, K_WR);    // leaves WR_SEL=11, WR_D0=1, prev_wr=1

        // Reset mid-HIGH: no strobe, outputs clear immediately
        nCPU_ROMSEL = 1'b0;
        nCPU_RW     = 1'b0;
        repeat (4) @(negedge CLK);
        CPU_M2 = 1'b1;
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        #1;
        check("midrst_wr_stb", int'(WR_STB), 0);
        check("midrst_wr_clr", int'(WR_CLR), 0);
        check("midrst_wr_d0", int'(WR_D0), 0);
        check("midrst_wr_sel", int'(WR_SEL), 0);
        check("midrst_ign_stb", int'(IGN_STB), 0);
        check("midrst_m2_lost", int'(M2_LOST), 0);
        @(negedge CLK);
        CPU_M2 = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (8) @(negedge CLK);
        bus_cycle(0, 0, 0, 0, 1, 0, 6, K_WR);    // prev_wr was reset

        repeat (20) @(negedge CLK);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
